// File: rtl/multi_reaction_timer.sv
// multi_reaction_timer
// Multi-player reaction timer. From IDLE, a start request begins DELAY,
// which lasts WAIT_MIN_MS plus the current LFSR value in ms. ARMED then
// lights the go-LED and counts milliseconds in BCD. The first eligible
// press ends the round, and RESULT holds the outcome for HOLD_MS before
// the timer returns to IDLE.
//
// Optional feature macro: FALSE_START_DETECT_EN
//   defined   : a press during DELAY marks that player as a false starter.
//               The player cannot win that round.
//   undefined : false_start is tied to 0 and presses in DELAY are ignored.
//
// Ports
//   Clk          rising-edge clock for every register
//   reset        synchronous, active-high reset
//   start        start request (pre-synchronised)
//   press        player buttons; bit i is player i (pre-synchronised)
//   led          go-light, high only in ARMED
//   state_leds   IDLE 000, DELAY 010, ARMED 100, RESULT 110
//   elapsed_bcd  reaction time, 4 BCD digits in ms
//   best_bcd     lowest winning time since reset, BCD
//   winner       one-hot winning player, zero when there is no winner
//   tie          more than one eligible press on the winning cycle
//   false_start  players who pressed during DELAY this round
module multi_reaction_timer #(
    parameter int NPLAYERS    = 2,
    parameter int TICK_DIV    = 50000,
    parameter int LFSR_W      = 12,
    parameter int WAIT_MIN_MS = 1000,
    parameter int HOLD_MS     = 1500
) (
    input  logic                Clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NPLAYERS-1:0] press,
    output logic                led,
    output logic [2:0]          state_leds,
    output logic [15:0]         elapsed_bcd,
    output logic [15:0]         best_bcd,
    output logic [NPLAYERS-1:0] winner,
    output logic                tie,
    output logic [NPLAYERS-1:0] false_start
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_DELAY  = 3'b010,
        S_ARMED  = 3'b100,
        S_RESULT = 3'b110
    } state_t;

    // Right-shift Galois feedback masks for maximal-length sequences.
    function automatic logic [15:0] taps_for(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0E08;
            13:      return 16'h1C80;
            14:      return 16'h3802;
            15:      return 16'h6000;
            default: return 16'hB400;
        endcase
    endfunction

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [15:0]       TAPS_ALL  = taps_for(LFSR_W);
    localparam logic [LFSR_W-1:0] LFSR_TAPS = TAPS_ALL[LFSR_W-1:0];
    localparam int PRE_W     = $clog2(TICK_DIV);
    localparam int DELAY_MAX = WAIT_MIN_MS + (1 << LFSR_W) - 1;
    localparam int MS_MAX    = (DELAY_MAX > HOLD_MS) ? DELAY_MAX : HOLD_MS;
    localparam int MS_W      = $clog2(MS_MAX + 1);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [PRE_W-1:0]    presc_q;
    logic [MS_W-1:0]     ms_cnt_q, ms_next, delay_ms_q;
    logic                tick, entering, delay_done, hold_done;
    logic                hit, timeout, all_false;
    logic [NPLAYERS-1:0] eligible;
    logic                led_d;
    logic [2:0]          state_leds_d;

    // NOTE: the LFSR is deliberately left out of reset so that each round
    // draws a fresh delay. The zero check recovers the power-up value and
    // seeds the register with 1.
    always_ff @(posedge Clk) begin
        if (lfsr_q == '0)
            lfsr_q <= LFSR_TAPS == '0 ? '0 : {{(LFSR_W-1){1'b0}}, 1'b1};
        else if (lfsr_q[0])
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ LFSR_TAPS;
        else
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]};
    end

    assign tick       = (presc_q == PRE_W'(TICK_DIV - 1));
    assign ms_next    = ms_cnt_q + MS_W'(1);
    assign delay_done = tick && (ms_next == delay_ms_q);
    assign hold_done  = tick && (ms_next == MS_W'(HOLD_MS));
    assign eligible   = press & ~false_start;
    assign hit        = |eligible;
    assign timeout    = (elapsed_bcd == 16'h9999);
    assign entering   = (state_d != state_q);

`ifdef FALSE_START_DETECT_EN
    logic [NPLAYERS-1:0] false_start_q;

    always_ff @(posedge Clk) begin
        if (reset)
            false_start_q <= '0;
        else if (state_q == S_IDLE && start)
            false_start_q <= '0;
        else if (state_q == S_DELAY)
            false_start_q <= false_start_q | press;
    end

    assign false_start = false_start_q;
    assign all_false   = &false_start_q;
`else
    assign false_start = '0;
    assign all_false   = 1'b0;
`endif

    // State register.
    // NOTE: sequential blocks use non-blocking assignments, so every
    // register sees the values that were present before the edge.
    always_ff @(posedge Clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: state_d gets its default first, so no path through the case
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)                       state_d = S_DELAY;
            S_DELAY:  if (delay_done)                  state_d = S_ARMED;
            S_ARMED:  if (hit || timeout || all_false) state_d = S_RESULT;
            S_RESULT: if (hold_done)                   state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state; the result is registered below.
    always_comb begin
        led_d        = (state_d == S_ARMED);
        state_leds_d = state_d;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            led         <= 1'b0;
            state_leds  <= S_IDLE;
            presc_q     <= '0;
            ms_cnt_q    <= '0;
            delay_ms_q  <= '0;
            elapsed_bcd <= 16'h0000;
            best_bcd    <= 16'h9999;
            winner      <= '0;
            tie         <= 1'b0;
        end else begin
            led        <= led_d;
            state_leds <= state_leds_d;

            // The prescaler and ms counter restart on every state change.
            if (entering || tick) presc_q <= '0;
            else                  presc_q <= presc_q + PRE_W'(1);

            if (entering)  ms_cnt_q <= '0;
            else if (tick) ms_cnt_q <= ms_next;

            case (state_q)
                S_IDLE: if (start) begin
                    delay_ms_q  <= MS_W'(WAIT_MIN_MS) + MS_W'(lfsr_q);
                    elapsed_bcd <= 16'h0000;
                    winner      <= '0;
                    tie         <= 1'b0;
                end
                S_ARMED: begin
                    if (hit) begin
                        // A press outranks a tick on the same cycle,
                        // so elapsed_bcd is left as it is.
                        winner <= eligible & (~eligible + NPLAYERS'(1));
                        tie    <= |(eligible & (eligible - NPLAYERS'(1)));
                        if (elapsed_bcd < best_bcd) best_bcd <= elapsed_bcd;
                    end else if (tick && state_d == S_ARMED) begin
                        elapsed_bcd <= bcd_inc(elapsed_bcd);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_reaction_timer.sv
// Randomised, scoreboarded bench for multi_reaction_timer.
// The stimulus process pushes the expected RESULT record whenever it ends a
// round. The monitor pops and compares that record when the DUT enters
// RESULT. Expected times come from cycle arithmetic: the delay is
// TICK_DIV * (WAIT_MIN_MS + lfsr) cycles, and elapsed is
// press_cycle / TICK_DIV ms.
module tb_multi_reaction_timer;

    localparam int NP          = 3;
    localparam int TICK_DIV    = 4;
    localparam int LFSR_W      = 12;
    localparam int WAIT_MIN_MS = 3;
    localparam int HOLD_MS     = 2;
    // Feedback mask of the design's 12-bit Galois register.
    localparam logic [11:0] TAPS = 12'hE08;

    logic          Clk = 1'b0;
    logic          reset;
    logic          start;
    logic [NP-1:0] press;
    logic          led;
    logic [2:0]    state_leds;
    logic [15:0]   elapsed_bcd;
    logic [15:0]   best_bcd;
    logic [NP-1:0] winner;
    logic          tie;
    logic [NP-1:0] false_start;

    always #5 Clk = ~Clk;

    multi_reaction_timer #(
        .NPLAYERS(NP), .TICK_DIV(TICK_DIV), .LFSR_W(LFSR_W),
        .WAIT_MIN_MS(WAIT_MIN_MS), .HOLD_MS(HOLD_MS)
    ) dut (
        .Clk(Clk), .reset(reset), .start(start), .press(press),
        .led(led), .state_leds(state_leds), .elapsed_bcd(elapsed_bcd),
        .best_bcd(best_bcd), .winner(winner), .tie(tie),
        .false_start(false_start)
    );

    typedef struct {
        logic [NP-1:0] winner;
        logic          tie;
        logic [15:0]   elapsed;
        logic [15:0]   best;
        logic [NP-1:0] fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference state: the LFSR sequence from power-up, the best time so far,
    // and this round's false starters.
    logic [11:0]   lfsr_m = '0;
    int            best_ms = 9999;
    logic [NP-1:0] fs_m;

    always @(posedge Clk)
        lfsr_m <= (lfsr_m == 12'd0) ? 12'd1
                : ((lfsr_m >> 1) ^ (lfsr_m[0] ? TAPS : 12'd0));

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Monitor: compares each RESULT entry against the oldest expectation.
    logic [2:0] prev_state = 3'b000;
    exp_t       mon_e;
    always @(negedge Clk) begin
        if (state_leds == 3'b110 && prev_state != 3'b110) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL result_unexpected: got RESULT entry expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("res_winner",  32'(winner),      32'(mon_e.winner));
                check("res_tie",     32'(tie),         32'(mon_e.tie));
                check("res_elapsed", 32'(elapsed_bcd), 32'(mon_e.elapsed));
                check("res_best",    32'(best_bcd),    32'(mon_e.best));
                check("res_fs",      32'(false_start), 32'(mon_e.fs));
            end
        end
        prev_state = state_leds;
    end

    // Wait at negedges until the LFSR value about to be latched suits the round.
    task automatic wait_lfsr(input bit want5);
        int n = 0;
        while (!(want5 ? (lfsr_m == 12'd5) : (lfsr_m < 12'd16)) && n < 5000) begin
            @(negedge Clk);
            n++;
        end
        check("lfsr_wait_bound", 32'(n < 5000), 32'd1);
    endtask

    // One full round. c is the ARMED cycle of the press (0 = first ARMED
    // cycle); no_press lets ARMED run until it times out.
    task automatic run_round(input bit want5, input logic [NP-1:0] ds_press,
                             input int ds_at, input int c,
                             input logic [NP-1:0] pr, input bit no_press);
        int            delay, cnt, el;
        logic [NP-1:0] elig, pr_eff;
        exp_t          e;

        wait_lfsr(want5);
        delay = WAIT_MIN_MS + int'(lfsr_m);
        fs_m  = '0;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("delay_entry", 32'(state_leds), 32'h2);
        check("start_clears_winner", 32'(winner), 32'h0);

        cnt = 0;
        while (!led && cnt < TICK_DIV * delay + 8) begin
            press = (cnt == ds_at) ? ds_press : '0;
            @(negedge Clk);
            cnt++;
        end
        press = '0;
`ifdef FALSE_START_DETECT_EN
        fs_m = ds_press;
`endif
        check("delay_cycles", 32'(cnt), 32'(TICK_DIV * delay));
        check("armed_code", 32'(state_leds), 32'h4);

        e.fs = fs_m;
        if (&fs_m) begin
            e.winner  = '0;
            e.tie     = 1'b0;
            e.elapsed = 16'h0000;
            e.best    = to_bcd(best_ms);
            exp_q.push_back(e);
        end else if (no_press) begin
            e.winner  = '0;
            e.tie     = 1'b0;
            e.elapsed = 16'h9999;
            e.best    = to_bcd(best_ms);
            exp_q.push_back(e);
        end else begin
            pr_eff = pr;
            if ((pr_eff & ~fs_m) == '0) begin
                for (int i = 0; i < NP; i++)
                    if (!fs_m[i]) begin pr_eff[i] = 1'b1; break; end
            end
            repeat (c) @(negedge Clk);
            press    = pr_eff;
            elig     = pr_eff & ~fs_m;
            e.winner = '0;
            for (int i = NP - 1; i >= 0; i--)
                if (elig[i]) e.winner = NP'(1) << i;
            e.tie     = ($countones(elig) > 1);
            el        = c / TICK_DIV;
            if (el < best_ms) best_ms = el;
            e.elapsed = to_bcd(el);
            e.best    = to_bcd(best_ms);
            exp_q.push_back(e);
            @(negedge Clk);
            press = '0;
        end

        cnt = 0;
        while (state_leds != 3'b110 && cnt < 45000) begin
            @(negedge Clk);
            cnt++;
        end
        check("result_reached", 32'(state_leds), 32'h6);

        // start and press in RESULT must be ignored.
        cnt = 0;
        while (state_leds != 3'b000 && cnt < 100) begin
            start = (cnt == 1);
            press = (cnt == 1) ? '1 : '0;
            @(negedge Clk);
            cnt++;
        end
        start = 1'b0;
        press = '0;
        check("hold_cycles", 32'(cnt), 32'(TICK_DIV * HOLD_MS));
        check("idle_led", 32'(led), 32'h0);
        check("idle_holds_winner", 32'(winner), 32'(e.winner));
        check("idle_holds_elapsed", 32'(elapsed_bcd), 32'(e.elapsed));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_led"},     32'(led),         32'h0);
        check({tag, "_state"},   32'(state_leds),  32'h0);
        check({tag, "_elapsed"}, 32'(elapsed_bcd), 32'h0);
        check({tag, "_best"},    32'(best_bcd),    32'h9999);
        check({tag, "_winner"},  32'(winner),      32'h0);
        check({tag, "_tie"},     32'(tie),         32'h0);
        check({tag, "_fs"},      32'(false_start), 32'h0);
    endtask

    task automatic reset_mid_armed();
        int cnt = 0;
        wait_lfsr(1'b0);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        while (!led && cnt < 200) begin
            @(negedge Clk);
            cnt++;
        end
        check("rst_armed_reached", 32'(state_leds), 32'h4);
        repeat (5) @(negedge Clk);
        reset = 1'b1;
        start = 1'b1;
        press = '1;
        @(negedge Clk);
        check_reset_values("rst_mid");
        reset   = 1'b0;
        start   = 1'b0;
        press   = '0;
        best_ms = 9999;
        @(negedge Clk);
        check("rst_stays_idle", 32'(state_leds), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        press = '0;
        repeat (3) @(negedge Clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge Clk);

        run_round(1'b1, '0,     0, 7 * TICK_DIV,     3'b010, 1'b0);
        run_round(1'b0, '0,     0, 5 * TICK_DIV + 3, 3'b101, 1'b0);
        run_round(1'b0, 3'b001, 2, 9,                3'b011, 1'b0);
        run_round(1'b0, 3'b111, 3, 6,                3'b100, 1'b0);
        for (int r = 0; r < 8; r++)
            run_round(1'b0,
                      ($urandom_range(0, 1) == 1) ? NP'($urandom_range(1, 7)) : '0,
                      $urandom_range(1, 10), $urandom_range(0, 50),
                      NP'($urandom_range(1, 7)), 1'b0);
        run_round(1'b0, '0, 0, 0, '0, 1'b1);
        reset_mid_armed();
        run_round(1'b0, '0, 0, 13, 3'b100, 1'b0);
        run_round(1'b0, '0, 0, $urandom_range(0, 40), NP'($urandom_range(1, 7)), 1'b0);

        repeat (2) @(negedge Clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_reaction_timer.md
MULTI_REACTION_TIMER -- requirements
Module: multi_reaction_timer

Interface
REQ-001 Parameter NPLAYERS, default 2: number of player buttons; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 50000: Clk cycles per 1 ms tick; legal minimum 2.
REQ-003 Parameter LFSR_W, default 12: random-delay LFSR width; legal range 4..16.
REQ-004 Parameter WAIT_MIN_MS, default 1000: minimum random delay in ms.
REQ-005 Parameter HOLD_MS, default 1500: time the result is held before IDLE, in ms.
REQ-006 Clk  input  1  one clock; every register is clocked on its rising edge.
REQ-007 reset  input  1  reset; synchronous, active-high.
REQ-008 start  input  1  active-high start request, sampled every cycle and already synchronised.
REQ-009 press  input  NPLAYERS  active-high player buttons, already synchronised; bit i is player i.
REQ-010 led  output  1  go-light; high only in ARMED.
REQ-011 state_leds  output  3  state code: IDLE 000, DELAY 010, ARMED 100, RESULT 110.
REQ-012 elapsed_bcd  output  16  reaction time in ms, 4 BCD digits, most significant digit at [15:12].
REQ-013 best_bcd  output  16  best (lowest) winning time since reset, BCD.
REQ-014 winner  output  NPLAYERS  one-hot winning player; all zero if there is no winner.
REQ-015 tie  output  1  more than one press bit was high on the winning cycle.
REQ-016 false_start  output  NPLAYERS  players who pressed during DELAY (sticky per round).

Function
REQ-017 LFSR: Galois, LFSR_W bits, nonzero seed 1, advances every cycle including during reset release; never holds zero.
REQ-018 Tick: prescaler emits a one-cycle pulse every TICK_DIV cycles; it is cleared to 0 on every state entry, so the first tick comes TICK_DIV cycles after entry.
REQ-019 IDLE -> DELAY on start=1; the same edge latches delay_ms = WAIT_MIN_MS + LFSR value, and clears elapsed_bcd, winner, tie and false_start.
REQ-020 DELAY: a binary ms counter increments per tick; DELAY -> ARMED on the tick where count+1 == delay_ms.
REQ-021 ARMED: elapsed_bcd increments by one BCD ms per tick with carry 9->0 per digit; it saturates at 9999.
REQ-022 ARMED -> RESULT on the first cycle with (press & ~false_start) != 0; winner = lowest eligible set index; tie = more than one eligible bit set; elapsed_bcd frozen at the value present that cycle (latency 1 cycle press->winner).
REQ-023 ARMED -> RESULT with winner=0 when elapsed_bcd reaches 9999 (timeout) or when every player is marked false_start.
REQ-024 A press and a tick in the same cycle: the press wins and the value excludes that tick's increment.
REQ-025 RESULT: best_bcd <= elapsed_bcd on entry when winner!=0 and elapsed_bcd < best_bcd; equal does not update.
REQ-026 RESULT -> IDLE after HOLD_MS ticks; start is ignored in RESULT and DELAY; press is ignored outside DELAY and ARMED.
REQ-027 Outputs are registered; they hold their values through IDLE until the next start.

Reset
REQ-028 reset=1 forces IDLE on the next edge from any state; led=0, state_leds=000, elapsed_bcd=0000, best_bcd=9999, winner=0, tie=0, false_start=0, prescaler=0, ms counter=0.
REQ-029 reset does not reseed the LFSR; reset dominates start and press in the same cycle.

Configuration
REQ-030 Macro FALSE_START_DETECT_EN defined: a press during DELAY sets that player's false_start bit, and the player is ineligible to win that round.
REQ-031 Macro FALSE_START_DETECT_EN undefined: false_start is tied to 0, presses in DELAY are ignored, and REQ-023's all-false-start exit is absent.

Verification (TICK_DIV=4, WAIT_MIN_MS=3, HOLD_MS=2, NPLAYERS=3)
REQ-032 reset, then start with LFSR=5 -> led rises 4*8 cycles after the DELAY entry and state_leds=100.
REQ-033 press=010 arrives after 7 ARMED ticks -> winner=010, elapsed_bcd=0007, tie=0, best_bcd=0007, IDLE 8 cycles after the RESULT entry.
REQ-034 press=101 arrives in ARMED -> winner=001, tie=1; if that press coincides with a tick, elapsed_bcd excludes that tick.
REQ-035 FALSE_START_DETECT_EN: press=001 in DELAY then press=011 in ARMED -> false_start=001, winner=010; press=111 in DELAY -> RESULT with winner=000.
REQ-036 No press in ARMED -> elapsed_bcd saturates at 9999, winner=000, best_bcd unchanged; reset asserted mid-ARMED -> IDLE next cycle with all REQ-028 values.
